// File: rtl/mp3_huff_pkg.sv
// Shared types, codeword tables and per-table limits for the MP3 big_values pair decoders.
package mp3_huff_pkg;

   localparam int CW_W        = 8;
   localparam int CNT_W       = 4;
   localparam int LIN_W       = 4;
   localparam int EXT_W       = 13;
   localparam int TBL_ID_STUB = 0;
   localparam int TBL5_N      = 16;
   localparam int STUB_N      = 2;

   typedef enum logic [2:0] {
      S_CW,
      S_LINX,
      S_SGNX,
      S_LINY,
      S_SGNY
   } huff_state_e;

   typedef struct packed {
      logic [CW_W-1:0]  code;
      logic [CNT_W-1:0] len;
      logic [3:0]       x;
      logic [3:0]       y;
   } cw_entry_t;

   // Codes are right-aligned: the last bit received sits in bit 0.
   localparam cw_entry_t TBL5 [TBL5_N] = '{
      '{8'h01, 4'd1, 4'd0, 4'd0},
      '{8'h02, 4'd3, 4'd0, 4'd1},
      '{8'h06, 4'd6, 4'd0, 4'd2},
      '{8'h05, 4'd7, 4'd0, 4'd3},
      '{8'h03, 4'd3, 4'd1, 4'd0},
      '{8'h01, 4'd3, 4'd1, 4'd1},
      '{8'h04, 4'd6, 4'd1, 4'd2},
      '{8'h04, 4'd7, 4'd1, 4'd3},
      '{8'h07, 4'd6, 4'd2, 4'd0},
      '{8'h05, 4'd6, 4'd2, 4'd1},
      '{8'h07, 4'd7, 4'd2, 4'd2},
      '{8'h01, 4'd8, 4'd2, 4'd3},
      '{8'h06, 4'd7, 4'd3, 4'd0},
      '{8'h01, 4'd6, 4'd3, 4'd1},
      '{8'h01, 4'd7, 4'd3, 4'd2},
      '{8'h00, 4'd8, 4'd3, 4'd3}
   };

   localparam cw_entry_t STUB_TBL [STUB_N] = '{
      '{8'h01, 4'd1, 4'd0, 4'd0},
      '{8'h01, 4'd2, 4'd0, 4'd1}
   };

   function automatic int max_cw_bits(input int table_id);
      case (table_id)
         TBL_ID_STUB: return 2;
         5:           return 8;
         default:     return CW_W;
      endcase
   endfunction

endpackage

// File: rtl/huff_pair_decoder_lut.sv
// Combinational codeword matcher: compares the bits gathered so far against the compiled table.
module huff_cw_lut
   import mp3_huff_pkg::*;
#(
   parameter int TABLE_ID = 5
)(
   input  logic [CW_W-1:0]  cw_buf_i,
   input  logic [CNT_W-1:0] cw_len_i,
   output logic             hit_o,
   output logic [3:0]       x_abs_o,
   output logic [3:0]       y_abs_o
);

   if (TABLE_ID == TBL_ID_STUB) begin : g_stub
      always_comb begin
         hit_o   = 1'b0;
         x_abs_o = '0;
         y_abs_o = '0;
         for (int i = 0; i < STUB_N; i++) begin
            if (cw_len_i == STUB_TBL[i].len && cw_buf_i == STUB_TBL[i].code) begin
               hit_o   = 1'b1;
               x_abs_o = STUB_TBL[i].x;
               y_abs_o = STUB_TBL[i].y;
            end
         end
      end
   end else begin : g_tbl5
      // Any other id falls back to table 5, the only full table compiled in.
      always_comb begin
         hit_o   = 1'b0;
         x_abs_o = '0;
         y_abs_o = '0;
         for (int i = 0; i < TBL5_N; i++) begin
            if (cw_len_i == TBL5[i].len && cw_buf_i == TBL5[i].code) begin
               hit_o   = 1'b1;
               x_abs_o = TBL5[i].x;
               y_abs_o = TBL5[i].y;
            end
         end
      end
   end

endmodule

// File: rtl/huff_pair_decoder.sv
// Bit-serial Huffman pair decoder: codeword match, escape linbits, signs, one signed (x,y) out.
//  state  | meaning
//  S_CW   | gathering codeword bits, matching after each bit
//  S_LINX | reading linbits extension for x (MSB first)
//  S_SGNX | reading sign bit of x
//  S_LINY | reading linbits extension for y (MSB first)
//  S_SGNY | reading sign bit of y
module huff_pair_decoder
   import mp3_huff_pkg::*;
#(
   parameter int TABLE_ID    = 5,
   parameter int MAX_CW_BITS = max_cw_bits(TABLE_ID),
   parameter int ESC_VAL     = 15,
   parameter int VAL_W       = 15
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    axiiv,
   input  logic                    axiid,
   input  logic [LIN_W-1:0]        linbits,
   output logic                    axiov,
   output logic                    err,
   output logic signed [VAL_W-1:0] x_val,
   output logic signed [VAL_W-1:0] y_val
);

   huff_state_e      state_q, state_d;
   logic [CW_W-1:0]  cw_q, cw_d, cw_shift;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [LIN_W-1:0] lin_q, lin_d;
   logic [LIN_W-1:0] rem_q, rem_d;
   logic [EXT_W-1:0] ext_q, ext_d;
   logic [VAL_W-1:0] mag_x_q, mag_x_d, mag_y_q, mag_y_d;
   logic             neg_x_q, neg_x_d, neg_y;
   logic             axiov_q, axiov_d, err_q, err_d;
   logic [VAL_W-1:0] x_val_q, x_val_d, y_val_q, y_val_d;
   logic             go_x, go_y, finish;
   logic             lut_hit;
   logic [3:0]       lut_x, lut_y;

   function automatic logic is_esc(input logic [VAL_W-1:0] mag, input logic [LIN_W-1:0] lin);
      return (mag == VAL_W'(ESC_VAL)) && (lin != '0);
   endfunction

   // Lookup sees the buffer including the bit arriving this cycle.
   assign cw_shift = {cw_q[CW_W-2:0], axiid};
   assign cnt_inc  = cnt_q + CNT_W'(1);

   huff_cw_lut #(.TABLE_ID(TABLE_ID)) u_lut (
      .cw_buf_i (cw_shift),
      .cw_len_i (cnt_inc),
      .hit_o    (lut_hit),
      .x_abs_o  (lut_x),
      .y_abs_o  (lut_y)
   );

   always_comb begin
      state_d = state_q;
      cw_d    = cw_q;
      cnt_d   = cnt_q;
      lin_d   = lin_q;
      rem_d   = rem_q;
      ext_d   = ext_q;
      mag_x_d = mag_x_q;
      mag_y_d = mag_y_q;
      neg_x_d = neg_x_q;
      neg_y   = 1'b0;
      axiov_d = 1'b0;
      err_d   = 1'b0;
      x_val_d = x_val_q;
      y_val_d = y_val_q;
      go_x    = 1'b0;
      go_y    = 1'b0;
      finish  = 1'b0;

      if (axiiv) begin
         unique case (state_q)
            S_CW: begin
               cw_d  = cw_shift;
               cnt_d = cnt_inc;
               if (cnt_q == '0) lin_d = linbits;
               if (lut_hit) begin
                  cw_d    = '0;
                  cnt_d   = '0;
                  mag_x_d = VAL_W'(lut_x);
                  mag_y_d = VAL_W'(lut_y);
                  neg_x_d = 1'b0;
                  go_x    = 1'b1;
               end else if (cnt_inc == CNT_W'(MAX_CW_BITS)) begin
                  cw_d  = '0;
                  cnt_d = '0;
                  err_d = 1'b1;
               end
            end
            S_LINX: begin
               ext_d = {ext_q[EXT_W-2:0], axiid};
               rem_d = rem_q - LIN_W'(1);
               if (rem_q == LIN_W'(1)) begin
                  mag_x_d = VAL_W'(ESC_VAL) + VAL_W'(ext_d);
                  if (mag_x_d != '0) state_d = S_SGNX;
                  else               go_y    = 1'b1;
               end
            end
            S_SGNX: begin
               neg_x_d = axiid;
               go_y    = 1'b1;
            end
            S_LINY: begin
               ext_d = {ext_q[EXT_W-2:0], axiid};
               rem_d = rem_q - LIN_W'(1);
               if (rem_q == LIN_W'(1)) begin
                  mag_y_d = VAL_W'(ESC_VAL) + VAL_W'(ext_d);
                  if (mag_y_d != '0) state_d = S_SGNY;
                  else               finish  = 1'b1;
               end
            end
            S_SGNY: begin
               neg_y  = axiid;
               finish = 1'b1;
            end
            default: state_d = S_CW;
         endcase
      end

      if (go_x) begin
         if (is_esc(mag_x_d, lin_d)) begin
            state_d = S_LINX;
            rem_d   = lin_d;
            ext_d   = '0;
         end else if (mag_x_d != '0) begin
            state_d = S_SGNX;
         end else begin
            go_y = 1'b1;
         end
      end

      if (go_y) begin
         if (is_esc(mag_y_d, lin_d)) begin
            state_d = S_LINY;
            rem_d   = lin_d;
            ext_d   = '0;
         end else if (mag_y_d != '0) begin
            state_d = S_SGNY;
         end else begin
            finish = 1'b1;
         end
      end

      // Returning to S_CW here lets a bit in the axiov cycle start the next codeword.
      if (finish) begin
         state_d = S_CW;
         axiov_d = 1'b1;
         x_val_d = neg_x_d ? (~mag_x_d + VAL_W'(1)) : mag_x_d;
         y_val_d = neg_y   ? (~mag_y_d + VAL_W'(1)) : mag_y_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CW;
         cw_q    <= '0;
         cnt_q   <= '0;
         lin_q   <= '0;
         rem_q   <= '0;
         ext_q   <= '0;
         mag_x_q <= '0;
         mag_y_q <= '0;
         neg_x_q <= 1'b0;
         axiov_q <= 1'b0;
         err_q   <= 1'b0;
         x_val_q <= '0;
         y_val_q <= '0;
      end else begin
         state_q <= state_d;
         cw_q    <= cw_d;
         cnt_q   <= cnt_d;
         lin_q   <= lin_d;
         rem_q   <= rem_d;
         ext_q   <= ext_d;
         mag_x_q <= mag_x_d;
         mag_y_q <= mag_y_d;
         neg_x_q <= neg_x_d;
         axiov_q <= axiov_d;
         err_q   <= err_d;
         x_val_q <= x_val_d;
         y_val_q <= y_val_d;
      end
   end

   assign axiov = axiov_q;
   assign err   = err_q;
   assign x_val = x_val_q;
   assign y_val = y_val_q;

endmodule

// File: tb/tb_huff_pair_decoder.sv
// Scoreboard bench: three decoder builds (table 5, table 5 with escape at 3, stub table).
module tb_huff_pair_decoder;

   localparam int VAL_W = 15;
   localparam int NI    = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst     [NI];
   logic                    axiiv   [NI];
   logic                    axiid   [NI];
   logic [3:0]              linbits [NI];
   logic                    axiov   [NI];
   logic                    err     [NI];
   logic signed [VAL_W-1:0] x_val   [NI];
   logic signed [VAL_W-1:0] y_val   [NI];

   huff_pair_decoder #(.TABLE_ID(5)) u_a (
      .clk(clk), .rst(rst[0]), .axiiv(axiiv[0]), .axiid(axiid[0]), .linbits(linbits[0]),
      .axiov(axiov[0]), .err(err[0]), .x_val(x_val[0]), .y_val(y_val[0]));

   huff_pair_decoder #(.TABLE_ID(5), .ESC_VAL(3)) u_e (
      .clk(clk), .rst(rst[1]), .axiiv(axiiv[1]), .axiid(axiid[1]), .linbits(linbits[1]),
      .axiov(axiov[1]), .err(err[1]), .x_val(x_val[1]), .y_val(y_val[1]));

   huff_pair_decoder #(.TABLE_ID(0)) u_s (
      .clk(clk), .rst(rst[2]), .axiiv(axiiv[2]), .axiid(axiid[2]), .linbits(linbits[2]),
      .axiov(axiov[2]), .err(err[2]), .x_val(x_val[2]), .y_val(y_val[2]));

   // Table 5 in ISO layout, indexed [x][y].
   int t5_len  [4][4] = '{'{1, 3, 6, 7}, '{3, 3, 6, 7}, '{6, 6, 7, 8}, '{7, 6, 7, 8}};
   int t5_code [4][4] = '{'{1, 2, 6, 5}, '{3, 1, 4, 4}, '{7, 5, 7, 1}, '{6, 1, 1, 0}};
   int esc_of  [NI]   = '{15, 3, 15};

   typedef struct {
      bit is_err;
      int x;
      int y;
   } exp_t;

   exp_t q_a[$];
   exp_t q_e[$];
   exp_t q_s[$];

   int tests = 0;
   int fails = 0;
   int last_x [NI];
   int last_y [NI];

   function automatic void check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic int q_size(int i);
      case (i)
         0:       return q_a.size();
         1:       return q_e.size();
         default: return q_s.size();
      endcase
   endfunction

   function automatic void push_exp(int i, exp_t e);
      case (i)
         0:       q_a.push_back(e);
         1:       q_e.push_back(e);
         default: q_s.push_back(e);
      endcase
   endfunction

   function automatic exp_t pop_exp(int i);
      case (i)
         0:       return q_a.pop_front();
         1:       return q_e.pop_front();
         default: return q_s.pop_front();
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      int   have;
      for (int i = 0; i < NI; i++) begin
         if (axiov[i] || err[i]) begin
            have = q_size(i);
            check($sformatf("expected_pending[%0d]", i), int'(have > 0), 1);
            if (have > 0) begin
               e = pop_exp(i);
               if (e.is_err) begin
                  check($sformatf("err_pulse[%0d]", i), int'(err[i]), 1);
                  check($sformatf("err_no_axiov[%0d]", i), int'(axiov[i]), 0);
                  check($sformatf("err_hold_x[%0d]", i), int'(x_val[i]), last_x[i]);
                  check($sformatf("err_hold_y[%0d]", i), int'(y_val[i]), last_y[i]);
               end else begin
                  check($sformatf("pair_axiov[%0d]", i), int'(axiov[i]), 1);
                  check($sformatf("pair_no_err[%0d]", i), int'(err[i]), 0);
                  check($sformatf("pair_x[%0d]", i), int'(x_val[i]), e.x);
                  check($sformatf("pair_y[%0d]", i), int'(y_val[i]), e.y);
                  last_x[i] = e.x;
                  last_y[i] = e.y;
               end
            end
         end
         if (rst[i]) begin
            last_x[i] = 0;
            last_y[i] = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int rand_gap();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
   endfunction

   task automatic send_bit(int i, bit b, int gap);
      repeat (gap) begin
         axiiv[i] = 1'b0;
         axiid[i] = 1'($urandom);
         tick();
      end
      axiiv[i] = 1'b1;
      axiid[i] = b;
      tick();
      axiiv[i] = 1'b0;
   endtask

   // gap < 0 selects random idle cycles before each bit.
   task automatic send_pair(int i, int xa, int ya, bit sx, bit sy, int lin, int ex, int ey, int gap);
      bit   bits[$];
      int   len, code, mx, my;
      exp_t e;
      if (i == 2) begin
         len  = (ya == 0) ? 1 : 2;
         code = 1;
      end else begin
         len  = t5_len[xa][ya];
         code = t5_code[xa][ya];
      end
      for (int k = len - 1; k >= 0; k--) bits.push_back(bit'((code >> k) & 1));
      mx = xa;
      my = ya;
      if (xa == esc_of[i] && lin != 0) begin
         for (int k = lin - 1; k >= 0; k--) bits.push_back(bit'((ex >> k) & 1));
         mx = xa + ex;
      end
      if (mx != 0) bits.push_back(sx);
      if (ya == esc_of[i] && lin != 0) begin
         for (int k = lin - 1; k >= 0; k--) bits.push_back(bit'((ey >> k) & 1));
         my = ya + ey;
      end
      if (my != 0) bits.push_back(sy);
      e.is_err = 1'b0;
      e.x = (mx != 0 && sx) ? -mx : mx;
      e.y = (my != 0 && sy) ? -my : my;
      push_exp(i, e);
      linbits[i] = 4'(lin);
      foreach (bits[k]) begin
         send_bit(i, bits[k], (gap < 0) ? rand_gap() : gap);
         if (k == 0) linbits[i] = 4'($urandom_range(0, 15));
      end
      check($sformatf("latency_axiov[%0d]", i), int'(axiov[i]), 1);
   endtask

   task automatic send_err(int i, int gap);
      exp_t e;
      e.is_err = 1'b1;
      e.x = 0;
      e.y = 0;
      push_exp(i, e);
      send_bit(i, 1'b0, (gap < 0) ? rand_gap() : gap);
      send_bit(i, 1'b0, (gap < 0) ? rand_gap() : gap);
      check($sformatf("latency_err[%0d]", i), int'(err[i]), 1);
   endtask

   task automatic check_reset_state(int i);
      check($sformatf("rst_axiov[%0d]", i), int'(axiov[i]), 0);
      check($sformatf("rst_err[%0d]", i), int'(err[i]), 0);
      check($sformatf("rst_x[%0d]", i), int'(x_val[i]), 0);
      check($sformatf("rst_y[%0d]", i), int'(y_val[i]), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int lin;
      for (int i = 0; i < NI; i++) begin
         rst[i]     = 1'b1;
         axiiv[i]   = 1'b0;
         axiid[i]   = 1'b0;
         linbits[i] = 4'd0;
         last_x[i]  = 0;
         last_y[i]  = 0;
      end
      repeat (3) tick();
      for (int i = 0; i < NI; i++) check_reset_state(i);
      for (int i = 0; i < NI; i++) rst[i] = 1'b0;
      tick();

      // Directed cases
      send_pair(0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
      send_pair(0, 0, 1, 1'b0, 1'b1, 0, 0, 0, 0);
      send_pair(0, 1, 0, 1'b0, 1'b0, 0, 0, 0, 0);
      send_pair(0, 1, 1, 1'b1, 1'b0, 0, 0, 0, 3);
      send_pair(1, 3, 3, 1'b1, 1'b0, 2, 2, 1, 0);
      send_err(2, 0);
      send_pair(2, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);

      // Reset in the middle of a codeword, with a valid bit in the reset cycle
      tick();
      send_bit(0, 1'b0, 0);
      send_bit(0, 1'b0, 0);
      send_bit(0, 1'b0, 0);
      rst[0]   = 1'b1;
      axiiv[0] = 1'b1;
      axiid[0] = 1'b1;
      tick();
      rst[0]   = 1'b0;
      axiiv[0] = 1'b0;
      check_reset_state(0);
      send_pair(0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 100; n++) begin
         send_pair(0, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 13), 0, 0, -1);
         lin = $urandom_range(0, 13);
         send_pair(1, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   lin, int'($urandom & ((1 << lin) - 1)), int'($urandom & ((1 << lin) - 1)), -1);
         if ($urandom_range(0, 4) == 0) send_err(2, -1);
         else send_pair(2, 0, $urandom_range(0, 1), 1'b0, 1'($urandom), 0, 0, 0, -1);
      end

      repeat (4) tick();
      for (int i = 0; i < NI; i++) check($sformatf("drained[%0d]", i), q_size(i), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
